mcp320x_scan_master: RTL

Parametrised SPI master for the MCP3002/3004/3008/3202/3204/3208 ADC family. It runs one conversion per fixed sample slot and scans channels round-robin. It generates SCK itself with a programmable divider, so no external SCK gating is needed. Each completed conversion is presented as a parallel word tagged with its channel number and a one-cycle valid pulse. It sits between the external ADC pins and the audio/analog sample consumers.

---
 rtl/mcp320x_scan_master.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mcp320x_scan_master.sv
// mcp320x_scan_master: round-robin SPI scan master for the MCP3002/3004/3008/3202/3204/3208.
// Runs one conversion per SAMPLE_PERIOD slot, generates SCK internally, and presents each
// result with its channel tag and a one-cycle data_valid pulse.
// Optional macro MCP320X_DIFF_EN adds a 'diff' input selecting pseudo-differential mode.
module mcp320x_scan_master #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned DATA_W        = 12,
    parameter int unsigned CLK_DIV       = 38,
    parameter int unsigned TCSH          = 64,
    parameter int unsigned SAMPLE_PERIOD = 2500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef MCP320X_DIFF_EN
    input  logic              diff,
`endif
    input  logic              miso,
    output logic              mosi,
    output logic              sck,
    output logic              cs_n,
    output logic [DATA_W-1:0] o_data,
    output logic [2:0]        o_ch,
    output logic              data_valid
);

    localparam int unsigned CMD_BITS = (NUM_CH == 2) ? 4 : 5;
    localparam int unsigned SKIP     = (NUM_CH == 2) ? 1 : 2;
    localparam int unsigned N_BITS   = CMD_BITS + SKIP + DATA_W;
    localparam int unsigned HALVES   = 2 * N_BITS;
    localparam int unsigned CNT_W    = $clog2(SAMPLE_PERIOD);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV + 1);
    localparam int unsigned HALF_W   = $clog2(HALVES + 1);

    localparam bit CFG_OK = ((NUM_CH == 2) || (NUM_CH == 4) || (NUM_CH == 8)) &&
                            ((DATA_W == 10) || (DATA_W == 12)) &&
                            (CLK_DIV >= 1) &&
                            (SAMPLE_PERIOD >= TCSH + 2 * CLK_DIV * N_BITS + 2);

    // Reject illegal parameter sets at elaboration
    if (!CFG_OK) begin : g_cfg_error
        $error("mcp320x_scan_master: illegal NUM_CH/DATA_W/CLK_DIV/TCSH/SAMPLE_PERIOD combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CS_HIGH,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [DIV_W-1:0]     r_div;
    logic [HALF_W-1:0]    r_half;
    logic [CMD_BITS-1:0]  r_cmd;
    logic [DATA_W-1:0]    r_shift;
    logic [2:0]           r_ch;

    logic                 w_cnt_wrap;
    logic                 w_frame_start;
    logic                 w_half_tick;
    logic                 w_last_half;
    logic                 w_sgl;
    logic                 w_ch2;
    logic [2:0]           w_ch_next;
    logic [CMD_BITS-1:0]  w_cmd;

`ifdef MCP320X_DIFF_EN
    assign w_sgl = ~diff;
`else
    assign w_sgl = 1'b1;
`endif

    assign w_cnt_wrap    = (r_cnt == CNT_W'(SAMPLE_PERIOD - 1));
    assign w_frame_start = (r_cnt == CNT_W'(TCSH));
    assign w_half_tick   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_half   = (r_half == HALF_W'(HALVES - 1));
    assign w_ch2         = (NUM_CH == 8) ? r_ch[2] : 1'b0;
    assign w_ch_next     = (r_ch == 3'(NUM_CH - 1)) ? 3'd0 : r_ch + 3'd1;

    // Command word for the current channel, START bit first
    always_comb begin
        if (NUM_CH == 2) begin
            w_cmd = CMD_BITS'({1'b1, w_sgl, r_ch[0], 1'b1});
        end else begin
            w_cmd = CMD_BITS'({1'b1, w_sgl, w_ch2, r_ch[1:0]});
        end
    end

    // Slot counter: free-runs over one sample period while enabled, parked at 0 otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!en || w_cnt_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Frame sequencer: CS/SCK/MOSI generation, MISO capture and result hand-off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_half     <= '0;
            r_cmd      <= '0;
            r_shift    <= '0;
            r_ch       <= 3'd0;
            cs_n       <= 1'b1;
            sck        <= 1'b0;
            mosi       <= 1'b0;
            o_data     <= '0;
            o_ch       <= 3'd0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (!en) begin
                // Abort: release the bus, keep channel and last result untouched
                r_state <= ST_IDLE;
                cs_n    <= 1'b1;
                sck     <= 1'b0;
                mosi    <= 1'b0;
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        if (w_half_tick) begin
                            r_div  <= '0;
                            r_half <= r_half + HALF_W'(1);
                            if (!r_half[0]) begin
                                // Rising SCK: sample mid-bit. Every bit is shifted in; the
                                // command and skip bits fall off the top, leaving DATA_W bits.
                                sck     <= 1'b1;
                                r_shift <= {r_shift[DATA_W-2:0], miso};
                            end else begin
                                sck <= 1'b0;
                                if (w_last_half) begin
                                    cs_n       <= 1'b1;
                                    mosi       <= 1'b0;
                                    o_data     <= r_shift;
                                    o_ch       <= r_ch;
                                    data_valid <= 1'b1;
                                    r_ch       <= w_ch_next;
                                    r_state    <= ST_DONE;
                                end else begin
                                    mosi  <= r_cmd[CMD_BITS-1];
                                    r_cmd <= {r_cmd[CMD_BITS-2:0], 1'b0};
                                end
                            end
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                    default: begin
                        if (w_frame_start) begin
                            // CS falls with START on MOSI; SGL/diff is frozen into r_cmd here
                            r_state <= ST_SHIFT;
                            cs_n    <= 1'b0;
                            sck     <= 1'b0;
                            mosi    <= w_cmd[CMD_BITS-1];
                            r_cmd   <= {w_cmd[CMD_BITS-2:0], 1'b0};
                            r_div   <= '0;
                            r_half  <= '0;
                        end else if (r_state == ST_IDLE || w_cnt_wrap) begin
                            r_state <= ST_CS_HIGH;
                        end
                    end
                endcase
            end
        end
    end

endmodule
